// File: rtl/temp_sched_pkg.sv
// Shared types and constants for the temperature read scheduler.
//   state_t       : read sequencer states
//   STAT_*        : bit positions inside the status byte
//   DEF_DEV_ADDR  : default 7-bit sensor address
//   DEF_TEMP_REG  : default sensor register pointer
package temp_sched_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    LATCH   = 3'd3,
    FAIL    = 3'd4,
    BACKOFF = 3'd5
  } state_t;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_VALID    = 1;
  localparam int STAT_LAST_ERR = 2;
  localparam int STAT_OVERRUN  = 3;

  localparam logic [6:0] DEF_DEV_ADDR = 7'h4B;
  localparam logic [7:0] DEF_TEMP_REG = 8'h00;

endpackage

// File: rtl/period_tick_gen.sv
// Free-running period timer.
//   clk, rst_n : clock / async active-low reset
//   enable     : 1 = count 0..PERIOD-1 and wrap, 0 = hold counter at 0
//   tick       : high for the one cycle the counter sits at PERIOD-1
module period_tick_gen #(
  parameter int PERIOD = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int CW = (PERIOD < 2) ? 1 : $clog2(PERIOD);

  logic [CW-1:0] cnt;
  logic          term;

  assign term = (cnt == CW'(PERIOD - 1));
  // Gated by enable so dropping enable on the terminal cycle suppresses the tick.
  assign tick = enable & term;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt <= '0;
    else if (!enable) cnt <= '0;
    else if (term)    cnt <= '0;
    else              cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/temp_read_scheduler.sv
// Sequences periodic / on-demand reads of the 16-bit temperature register via the
// I2C master and holds the last good sample. Adds timeout, NACK retry with backoff,
// error counting and a status byte.
//   enable, oneshot                 : periodic sampling enable / one-cycle read request
//   i2c_busy/done/nack/rdata        : I2C master handshake and read data
//   i2c_start/dev_addr/reg_addr     : transaction launch pulse and constant addressing
//   temp, sample_cnt, err_cnt       : last good sample, good-read count, abandoned-read count
//   status                          : {4'b0, overrun, last_err, temp_valid, busy}
module temp_read_scheduler
  import temp_sched_pkg::*;
#(
  parameter int         SAMPLE_PERIOD  = 10_000_000,
  parameter int         TIMEOUT_CYCLES = 200_000,
  parameter int         MAX_RETRY      = 3,
  parameter int         BACKOFF_CYCLES = 16,
  parameter logic [6:0] DEV_ADDR       = DEF_DEV_ADDR,
  parameter logic [7:0] TEMP_REG       = DEF_TEMP_REG
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        oneshot,
  input  logic        i2c_busy,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  input  logic [15:0] i2c_rdata,
  output logic        i2c_start,
  output logic [6:0]  i2c_dev_addr,
  output logic [7:0]  i2c_reg_addr,
  output logic [15:0] temp,
  output logic [7:0]  sample_cnt,
  output logic [7:0]  err_cnt,
  output logic [7:0]  status
);

  localparam int TMAX = (TIMEOUT_CYCLES > BACKOFF_CYCLES) ? TIMEOUT_CYCLES : BACKOFF_CYCLES;
  localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);
  localparam int RW   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  state_t        state;
  logic          tick;
  logic          req;
  logic          pending;
  logic [RW-1:0] retries;
  logic [TW-1:0] tmr;       // timeout in WAIT, backoff in BACKOFF; never both
  logic [15:0]   rdata_q;
  logic          temp_valid;
  logic          last_err;
  logic          overrun;

  period_tick_gen #(.PERIOD(SAMPLE_PERIOD)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .tick   (tick)
  );

  assign req          = tick | oneshot;
  assign i2c_dev_addr = DEV_ADDR;
  assign i2c_reg_addr = TEMP_REG;

  always_comb begin
    status                = '0;
    status[STAT_BUSY]     = (state != IDLE);
    status[STAT_VALID]    = temp_valid;
    status[STAT_LAST_ERR] = last_err;
    status[STAT_OVERRUN]  = overrun;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pending    <= 1'b0;
      retries    <= '0;
      tmr        <= '0;
      rdata_q    <= '0;
      i2c_start  <= 1'b0;
      temp       <= '0;
      sample_cnt <= '0;
      err_cnt    <= '0;
      temp_valid <= 1'b0;
      last_err   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      i2c_start <= 1'b0;
      // Requests are never queued behind a running read; flag the loss instead.
      if (req && state != IDLE) overrun <= 1'b1;

      case (state)
        IDLE: begin
          // A request landing on the cycle pending is consumed merges into that read.
          if (pending) begin
            pending <= 1'b0;
            retries <= '0;
            state   <= ISSUE;
          end else if (req) begin
            pending <= 1'b1;
          end
        end
        ISSUE: begin
          if (!i2c_busy) begin
            i2c_start <= 1'b1;
            tmr       <= TW'(TIMEOUT_CYCLES - 1);
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (i2c_done && !i2c_nack) begin
            rdata_q <= i2c_rdata;
            state   <= LATCH;
          end else if (i2c_done || tmr == '0) begin
            state <= FAIL;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        LATCH: begin
          temp       <= rdata_q;
          sample_cnt <= sample_cnt + 8'd1;
          temp_valid <= 1'b1;
          last_err   <= 1'b0;
          state      <= IDLE;
        end
        FAIL: begin
          if (retries < RW'(MAX_RETRY)) begin
            retries <= retries + RW'(1);
            tmr     <= TW'(BACKOFF_CYCLES - 1);
            state   <= BACKOFF;
          end else begin
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            last_err <= 1'b1;
            state    <= IDLE;
          end
        end
        BACKOFF: begin
          if (tmr == '0) state <= ISSUE;
          else           tmr   <= tmr - TW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_temp_read_scheduler.sv
module tb_temp_read_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        oneshot;
  logic        i2c_busy;
  logic        i2c_done;
  logic        i2c_nack;
  logic [15:0] i2c_rdata;
  logic        i2c_start;
  logic [6:0]  i2c_dev_addr;
  logic [7:0]  i2c_reg_addr;
  logic [15:0] temp;
  logic [7:0]  sample_cnt;
  logic [7:0]  err_cnt;
  logic [7:0]  status;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int nstarts    = 0;
  int wide_cnt   = 0;
  logic start_prev = 1'b0;

  // sensor model knobs (written only by the stimulus block)
  int          lat        = 20;
  int          nack_limit = 0;
  bit          never_done = 1'b0;
  logic [15:0] rdata_val  = 16'h0C80;
  int          nack_total = 0;   // written only by the model

  int last_n;
  int t1, t2, t3, s0, n;

  temp_read_scheduler #(
    .SAMPLE_PERIOD  (100),
    .TIMEOUT_CYCLES (50),
    .MAX_RETRY      (3),
    .BACKOFF_CYCLES (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .oneshot      (oneshot),
    .i2c_busy     (i2c_busy),
    .i2c_done     (i2c_done),
    .i2c_nack     (i2c_nack),
    .i2c_rdata    (i2c_rdata),
    .i2c_start    (i2c_start),
    .i2c_dev_addr (i2c_dev_addr),
    .i2c_reg_addr (i2c_reg_addr),
    .temp         (temp),
    .sample_cnt   (sample_cnt),
    .err_cnt      (err_cnt),
    .status       (status)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (i2c_start === 1'b1) begin
      nstarts <= nstarts + 1;
      if (start_prev === 1'b1) wide_cnt <= wide_cnt + 1;
    end
    start_prev <= i2c_start;
  end

  // I2C master model: answers each start after 'lat' cycles unless never_done.
  initial begin
    i2c_done  = 1'b0;
    i2c_nack  = 1'b0;
    i2c_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (i2c_start === 1'b1 && !never_done) begin
        repeat (lat - 1) @(negedge clk);
        i2c_done = 1'b1;
        if (nack_total < nack_limit) begin
          i2c_nack   = 1'b1;
          i2c_rdata  = 16'hDEAD;
          nack_total = nack_total + 1;
        end else begin
          i2c_nack  = 1'b0;
          i2c_rdata = rdata_val;
        end
        @(negedge clk);
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_start(input int budget, input string tag);
    int k = 0;
    while (i2c_start !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    last_n = k;
    check(tag, {31'd0, i2c_start}, 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (status[0] !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, {31'd0, status[0]}, 32'd0);
  endtask

  task automatic do_oneshot();
    oneshot = 1'b1;
    @(negedge clk);
    oneshot = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; oneshot = 1'b0; i2c_busy = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_start",  {31'd0, i2c_start}, 32'd0);
    check("rst_temp",   {16'd0, temp}, 32'd0);
    check("rst_samp",   {24'd0, sample_cnt}, 32'd0);
    check("rst_err",    {24'd0, err_cnt}, 32'd0);
    check("rst_status", {24'd0, status}, 32'd0);
    check("dev_addr",   {25'd0, i2c_dev_addr}, 32'h4B);
    check("reg_addr",   {24'd0, i2c_reg_addr}, 32'h00);

    // periodic sampling
    rst_n = 1'b1; enable = 1'b1; lat = 20; rdata_val = 16'h0C80;
    wait_start(200, "per_start1"); t1 = cyc;
    repeat (30) @(negedge clk);
    check("per_temp",   {16'd0, temp}, 32'h0C80);
    check("per_samp1",  {24'd0, sample_cnt}, 32'd1);
    check("per_status", {24'd0, status}, 32'h02);
    wait_start(200, "per_start2"); t2 = cyc;
    check("per_interval", t2 - t1, 32'd100);
    repeat (30) @(negedge clk);
    check("per_samp2", {24'd0, sample_cnt}, 32'd2);
    enable = 1'b0;

    // two NACKs then success
    lat = 3; rdata_val = 16'h0D10; nack_limit = nack_total + 2;
    s0 = nstarts;
    do_oneshot();
    wait_start(60, "nack_start1"); t1 = cyc; @(negedge clk);
    wait_start(60, "nack_start2"); t2 = cyc; @(negedge clk);
    wait_start(60, "nack_start3"); t3 = cyc;
    check("nack_gap1", {31'd0, (t2 - t1) >= 16}, 32'd1);
    check("nack_gap2", {31'd0, (t3 - t2) >= 16}, 32'd1);
    repeat (40) @(negedge clk);
    check("nack_starts", nstarts - s0, 32'd3);
    check("nack_samp",   {24'd0, sample_cnt}, 32'd3);
    check("nack_err",    {24'd0, err_cnt}, 32'd0);
    check("nack_temp",   {16'd0, temp}, 32'h0D10);
    check("nack_status", {24'd0, status}, 32'h02);

    // timeout on every attempt
    never_done = 1'b1;
    s0 = nstarts;
    do_oneshot();
    wait_idle(600, "to_idle");
    repeat (2) @(negedge clk);
    check("to_starts", nstarts - s0, 32'd4);
    check("to_err",    {24'd0, err_cnt}, 32'd1);
    check("to_temp",   {16'd0, temp}, 32'h0D10);
    check("to_samp",   {24'd0, sample_cnt}, 32'd3);
    check("to_status", {24'd0, status}, 32'h06);
    never_done = 1'b0;

    // oneshot coincident with tick, then oneshot during WAIT
    lat = 20; rdata_val = 16'h0CF0;
    enable = 1'b1;
    repeat (99) @(negedge clk);
    s0 = nstarts;
    oneshot = 1'b1;
    @(negedge clk);
    oneshot = 1'b0;
    wait_start(10, "coinc_start");
    repeat (4) @(negedge clk);
    oneshot = 1'b1;
    @(negedge clk);
    oneshot = 1'b0;
    repeat (25) @(negedge clk);
    check("ovr_status", {24'd0, status}, 32'h0A);
    check("ovr_samp",   {24'd0, sample_cnt}, 32'd4);
    check("ovr_temp",   {16'd0, temp}, 32'h0CF0);
    repeat (30) @(negedge clk);
    check("coinc_starts", nstarts - s0, 32'd1);
    enable = 1'b0;

    // i2c_busy holds off the start
    rdata_val = 16'h0E40;
    i2c_busy = 1'b1;
    s0 = nstarts;
    do_oneshot();
    repeat (27) @(negedge clk);
    check("busy_status", {24'd0, status}, 32'h0B);
    check("busy_nostart", nstarts - s0, 32'd0);
    i2c_busy = 1'b0;
    @(negedge clk);
    check("busy_rel_start", {31'd0, i2c_start}, 32'd1);
    @(negedge clk);
    check("busy_start_w", {31'd0, i2c_start}, 32'd0);
    n = 0;
    while (i2c_done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    check("lat_done_seen", {31'd0, i2c_done}, 32'd1);
    @(negedge clk);
    check("lat_before", {16'd0, temp}, 32'h0CF0);
    @(negedge clk);
    check("lat_after",  {16'd0, temp}, 32'h0E40);
    check("lat_samp",   {24'd0, sample_cnt}, 32'd5);

    // async reset during WAIT
    never_done = 1'b1;
    do_oneshot();
    wait_start(10, "rst_wait_start");
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_start",  {31'd0, i2c_start}, 32'd0);
    check("arst_temp",   {16'd0, temp}, 32'd0);
    check("arst_samp",   {24'd0, sample_cnt}, 32'd0);
    check("arst_err",    {24'd0, err_cnt}, 32'd0);
    check("arst_status", {24'd0, status}, 32'd0);
    @(negedge clk);
    never_done = 1'b0; enable = 1'b1; rst_n = 1'b1;
    wait_start(200, "arst_first");
    check("arst_first_tick", {31'd0, (last_n >= 100 && last_n <= 103)}, 32'd1);
    repeat (30) @(negedge clk);
    check("arst_samp1", {24'd0, sample_cnt}, 32'd1);
    check("arst_temp1", {16'd0, temp}, 32'h0E40);
    enable = 1'b0;

    // err_cnt saturation
    lat = 1; nack_limit = 32'h7FFF_FFFF;
    for (int i = 0; i < 255; i++) begin
      do_oneshot();
      wait_idle(200, "sat_idle");
    end
    check("sat_255",    {24'd0, err_cnt}, 32'd255);
    check("sat_status", {24'd0, status}, 32'h06);
    do_oneshot();
    wait_idle(200, "sat_idle_last");
    check("sat_hold",   {24'd0, err_cnt}, 32'd255);
    check("sat_temp",   {16'd0, temp}, 32'h0E40);

    @(negedge clk);
    check("start_width", wide_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
